// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//
// Contents:
//   LEN_*      cfg_len codes (number of data bits, 5..8)
//   PAR_*      cfg_parity codes (code 3 also means no parity)
//   state_e    transmitter FSM state encoding
//   div_reset  rounded clock-cycles-per-bit for a clock/baud pair
//   last_data_idx / data_mask  helpers derived from a cfg_len code
package uart_pkg;

   localparam logic [1:0] LEN_5 = 2'd0;
   localparam logic [1:0] LEN_6 = 2'd1;
   localparam logic [1:0] LEN_7 = 2'd2;
   localparam logic [1:0] LEN_8 = 2'd3;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_e;

   // Nearest-integer divisor: (f + b/2) / b.
   function automatic int div_reset(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

   // Index of the last data bit sent for a given length code (4..7).
   function automatic logic [2:0] last_data_idx(input logic [1:0] len);
      return 3'd4 + {1'b0, len};
   endfunction

   // Selects the data bits that take part in the frame (and the parity).
   function automatic logic [7:0] data_mask(input logic [1:0] len);
      logic [7:0] m;
      m = 8'hFF;
      case (len)
         LEN_5: m = 8'h1F;
         LEN_6: m = 8'h3F;
         LEN_7: m = 8'h7F;
         LEN_8: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-available FIFO.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push       write wdata this cycle; ignored while full
//   wdata      word to write
//   pop        consume the word on rdata; ignored while empty
//   rdata      oldest stored word, valid whenever empty is low
//   full       DEPTH words held
//   empty      no words held
//   count      number of words held, 0..DEPTH
//
// A pushed word is visible on rdata the cycle after the push edge.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with an input FIFO.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   s_data       word to send, LSB first; bits above the length are ignored
//   s_valid      s_data holds a word
//   s_ready      FIFO has room
//   cfg_len      data bits: 0=5, 1=6, 2=7, 3=8
//   cfg_parity   0=none, 1=even, 2=odd, 3=none
//   cfg_stop2    two stop bits when set
//   cfg_div      clock cycles per bit; values below 2 act as 2
//   brk          line-break request
//   tx_out       registered serial line, idles high
//   tx_busy      frame, break or post-break guard time in progress
//   tx_done      one-cycle pulse after the last stop bit of each frame
//   fifo_count   words waiting in the FIFO
//
// Handshake: a word is transferred on every rising edge where s_valid and
// s_ready are both high. s_ready depends only on FIFO occupancy, never on
// s_valid. s_data must be stable while s_valid is high and not yet taken.
//
// Frame format and divisor are captured when a word is popped, so cfg_*
// changes only affect frames that have not started yet. Each bit state is
// entered on the same edge that drives its value onto tx_out, and lasts
// exactly D cycles as counted by bit_cnt.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 80_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int DIV_W     = 16,
   parameter int DEPTH     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [1:0]             cfg_len,
   input  logic [1:0]             cfg_parity,
   input  logic                   cfg_stop2,
   input  logic [DIV_W-1:0]       cfg_div,
   input  logic                   brk,
   output logic                   tx_out,
   output logic                   tx_busy,
   output logic                   tx_done,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int DIV_RESET = div_reset(CLK_FREQ, BAUD_RATE);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0] guard_cnt_q, guard_cnt_d;
   logic             guard_q, guard_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       len_q, len_d;
   logic [1:0]       par_q, par_d;
   logic             stop2_q, stop2_d;
   logic             stop_half_q, stop_half_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;

   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_rdata;
   logic             start_frame, enter_break;
   logic [DIV_W-1:0] div_clamped;
   logic             bit_end, guard_end;
   logic             par_en, par_bit;
   logic [2:0]       last_idx;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid),
      .wdata (s_data),
      .pop   (start_frame),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign s_ready     = !fifo_full;
   assign div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
   assign bit_end     = (bit_cnt_q == div_q - DIV_W'(1));
   assign guard_end   = (guard_cnt_q == div_q - DIV_W'(1));
   assign last_idx    = last_data_idx(len_q);
   assign par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   // Even parity bit is the XOR of the sent data bits; odd inverts it.
   assign par_bit     = (^(data_q & data_mask(len_q))) ^ (par_q == PAR_ODD);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      guard_cnt_d = guard_cnt_q;
      guard_d     = guard_q;
      idx_d       = idx_q;
      data_d      = data_q;
      len_d       = len_q;
      par_d       = par_q;
      stop2_d     = stop2_q;
      stop_half_d = stop_half_q;
      div_d       = div_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
      start_frame = 1'b0;
      enter_break = 1'b0;

      if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
         bit_cnt_d = bit_end ? '0 : bit_cnt_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (guard_q) begin
               if (guard_end) guard_d = 1'b0;
               else           guard_cnt_d = guard_cnt_q + DIV_W'(1);
            end
            // The edge that completes the guard time may already start work.
            if (!guard_q || guard_end) begin
               if (brk)              enter_break = 1'b1;
               else if (!fifo_empty) start_frame = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               idx_d   = 3'd0;
               tx_d    = data_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == last_idx) begin
                  if (par_en) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit;
                  end else begin
                     state_d     = ST_STOP;
                     stop_half_d = 1'b0;
                     tx_d        = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = data_q[idx_q + 3'd1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d     = ST_STOP;
               stop_half_d = 1'b0;
               tx_d        = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_half_q) begin
                  // Second stop bit: stay in STOP for another D cycles.
                  stop_half_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (brk)              enter_break = 1'b1;
                  else if (!fifo_empty) start_frame = 1'b1;
                  else                  state_d = ST_IDLE;
               end
            end
         end
         ST_BREAK: begin
            if (!brk) begin
               state_d     = ST_IDLE;
               tx_d        = 1'b1;
               guard_d     = 1'b1;
               guard_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (start_frame) begin
         state_d   = ST_START;
         tx_d      = 1'b0;
         bit_cnt_d = '0;
         data_d    = fifo_rdata;
         len_d     = cfg_len;
         par_d     = cfg_parity;
         stop2_d   = cfg_stop2;
         div_d     = div_clamped;
      end

      if (enter_break) begin
         state_d = ST_BREAK;
         tx_d    = 1'b0;
         // Divisor captured here times the guard after the break ends.
         div_d   = div_clamped;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         guard_cnt_q <= '0;
         guard_q     <= 1'b0;
         idx_q       <= 3'd0;
         data_q      <= 8'h00;
         len_q       <= LEN_8;
         par_q       <= PAR_NONE;
         stop2_q     <= 1'b0;
         stop_half_q <= 1'b0;
         div_q       <= DIV_W'(DIV_RESET);
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         guard_cnt_q <= guard_cnt_d;
         guard_q     <= guard_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         len_q       <= len_d;
         par_q       <= par_d;
         stop2_q     <= stop2_d;
         stop_half_q <= stop_half_d;
         div_q       <= div_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
      end
   end

   assign tx_out  = tx_q;
   assign tx_done = done_q;
   assign tx_busy = (state_q != ST_IDLE) || guard_q;

endmodule
